lfsr_prbs_gen: RTL
==================

Name: lfsr_prbs_gen

Overview:
- Parametrised Fibonacci LFSR pseudo-random generator. It is the successor to the fixed 8-bit LFSR used for test data in the eth_pdm_fft benches.
- Adds generic width and tap mask, and advances STEP bits per transfer.
- Adds a valid/ready output handshake, runtime seed load, all-zero lockup protection, a transfer counter and a sequence-wrap flag.
- Feeds stimulus words to DUT streams and checkers.

Parameters:
- WIDTH, 8: LFSR state width in bits, 3..32.
- TAPS, 8'hB8: feedback tap mask, WIDTH bits; bit i set means state[i] enters the XOR.
- SEED, 8'hFF: reset and fallback seed, WIDTH bits, must be non-zero.
- STEP, 1: shifts applied per accepted word, 1..WIDTH.
- CNT_W, 32: width of the transfer counter.

Ports:
- clk, input, 1: clock, rising edge.
- rst, input, 1: asynchronous, active-low reset. Asserted when 0.
- en, input, 1: generator enable.
- seed_load, input, 1: synchronous seed load strobe.
- seed_in, input, WIDTH: seed value, sampled when seed_load=1.
- out_data, output, WIDTH: current LFSR state.
- out_valid, output, 1: out_data is offered.
- out_ready, input, 1: consumer accepts out_data.
- lockup, output, 1: one-cycle pulse, a zero seed was rejected.
- wrap, output, 1: one-cycle pulse, state returned to the last loaded seed.
- xfer_cnt, output, CNT_W: number of accepted words since reset or load.

Behaviour:
- Reset (rst=0, async): state=SEED, last_seed=SEED, valid_q=0, lockup=0, wrap=0, xfer_cnt=0.
- valid_q sets to 1 on the first clk edge after reset release.
- out_valid = valid_q & en & ~seed_load, combinational. out_data = state, registered.
- Single shift, Fibonacci: fb = ^(state & TAPS); next = {state[WIDTH-2:0], fb}.
- A transfer advances the state by STEP chained single shifts, unrolled within one cycle.
- Transfer = out_valid & out_ready. On a transfer edge:
  - state <= step^STEP(state).
  - xfer_cnt <= xfer_cnt+1, wrapping modulo 2^CNT_W.
  - The new state is visible the next cycle.
- No transfer (en=0, or out_ready=0): state and xfer_cnt hold. out_data stays stable while out_valid=1 and out_ready=0.
- Seed load has highest priority and overrides a transfer in the same cycle, since out_valid=0 then. On seed_load=1:
  - seed_in != 0: state <= seed_in, last_seed <= seed_in, xfer_cnt <= 0.
  - seed_in == 0: state <= SEED, last_seed <= SEED, xfer_cnt <= 0, lockup pulses 1 the next cycle.
- Lockup guard: if state is ever 0 at a clk edge (SEU or illegal seed), state <= SEED and lockup pulses.
- wrap: registered pulse, asserted the cycle after a transfer whose next state equals last_seed.
- Back-to-back transfers are supported with out_ready held high, one word per cycle with no bubbles.
- rst asserted mid-stream: all outputs return to reset values immediately, asynchronously.
- lockup and wrap are single-cycle pulses and never stick.
- With TAPS maximal, for example 8'hB8 = x^8+x^6+x^5+x^4+1, the period is 2^WIDTH-1 single shifts.

Test Plan:
- Reset then en=1, out_ready=1, defaults: out_data sequence FF, FE, FC, F8, F0, E1. xfer_cnt counts 1,2,3... out_valid=0 in the first cycle after reset release.
- STEP=2, defaults otherwise: sequence FF, FC, F0 (every second single-shift state).
- Backpressure: out_ready toggled 1,0,0,1 -> out_data holds FE across the stalled cycles. No values are skipped or duplicated. xfer_cnt increments only on accepted cycles.
- Seed load:
  - seed_in=8'h01 -> next out_data=01, then 02, 04. xfer_cnt restarts from 0.
  - seed_in=8'h00 -> out_data=FF and lockup pulses for exactly 1 cycle.
- Period: 255 consecutive transfers from FF -> wrap pulses once, on the 255th transfer, with out_data=FF again. No repeats occur earlier; the bench checks all 255 values are unique.
- Async reset asserted mid-burst with out_ready=1 -> out_valid=0, out_data=FF and xfer_cnt=0 without waiting for a clk edge. The sequence restarts from FF after release.

Source files
------------

// File: rtl/lfsr_prbs_gen.sv
// Parametrised Fibonacci LFSR stimulus generator.
// Emits the current LFSR state as a word over a valid/ready handshake and
// advances STEP single shifts per accepted word. It also provides runtime
// seed load, all-zero lockup recovery, a transfer counter and a
// sequence-wrap pulse.
module lfsr_prbs_gen #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(8'hB8),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(8'hFF),
  parameter int               STEP  = 1,
  parameter int               CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_in,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             lockup,
  output logic             wrap,
  output logic [CNT_W-1:0] xfer_cnt
);

  logic [WIDTH-1:0] r_state;
  logic [WIDTH-1:0] r_last_seed;
  logic             r_valid_q;
  logic             r_lockup;
  logic             r_wrap;
  logic [CNT_W-1:0] r_xfer_cnt;

  logic             w_xfer;
  logic [WIDTH-1:0] w_next;

  // One Fibonacci shift: the tapped bits XOR into the new LSB.
  function automatic logic [WIDTH-1:0] shift1(input logic [WIDTH-1:0] s);
    return {s[WIDTH-2:0], ^(s & TAPS)};
  endfunction

  // STEP chained shifts, unrolled into one combinational cone.
  function automatic logic [WIDTH-1:0] shift_step(input logic [WIDTH-1:0] s);
    logic [WIDTH-1:0] t;
    t = s;
    for (int i = 0; i < STEP; i++) begin
      t = shift1(t);
    end
    return t;
  endfunction

  // A seed load masks the offer, so a load can never coincide with a transfer.
  assign out_valid = r_valid_q & en & ~seed_load;
  assign w_xfer    = out_valid & out_ready;
  assign w_next    = shift_step(r_state);

  assign out_data  = r_state;
  assign lockup    = r_lockup;
  assign wrap      = r_wrap;
  assign xfer_cnt  = r_xfer_cnt;

  // State, seed memory, counter and pulses. Priority: seed load, then
  // zero-state recovery, then a normal transfer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= SEED;
      r_last_seed <= SEED;
      r_valid_q   <= 1'b0;
      r_lockup    <= 1'b0;
      r_wrap      <= 1'b0;
      r_xfer_cnt  <= '0;
    end else begin
      r_valid_q <= 1'b1;
      r_lockup  <= 1'b0;
      r_wrap    <= 1'b0;
      if (seed_load) begin
        r_xfer_cnt <= '0;
        if (seed_in != '0) begin
          r_state     <= seed_in;
          r_last_seed <= seed_in;
        end else begin
          r_state     <= SEED;
          r_last_seed <= SEED;
          r_lockup    <= 1'b1;
        end
      end else if (r_state == '0) begin
        // An all-zero state would stick forever; fall back to the seed.
        r_state  <= SEED;
        r_lockup <= 1'b1;
      end else if (w_xfer) begin
        r_state    <= w_next;
        r_xfer_cnt <= r_xfer_cnt + CNT_W'(1);
        r_wrap     <= (w_next == r_last_seed);
      end
    end
  end

endmodule
